posit_acc_normalizer: RTL and testbench



---
 rtl/posit_pkg.sv | 28 ++
 rtl/leading_one_detector.sv | 23 ++
 rtl/posit_acc_normalizer.sv | 208 ++++++++++++++++++++
 tb/tb_posit_acc_normalizer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared definitions for the posit accumulate/normalize path: sizing helpers and FSM states.
package posit_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_NORM  = 2'd1,
    ST_NORM2 = 2'd2,
    ST_OUT   = 2'd3
  } acc_state_e;

  function automatic int clog2(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < x) r = i + 1;
    return r;
  endfunction

  function automatic int scale_max(input int n, input int es);
    return (n - 2) << es;
  endfunction

  // Sign + guard bits + full scale span + fraction + hidden bit.
  function automatic int acc_width(input int n, input int es, input int mant_w, input int carry_bits);
    return 1 + carry_bits + 2 * scale_max(n, es) + mant_w + 1;
  endfunction

endpackage

// File: rtl/leading_one_detector.sv
// Priority encoder returning the index of the most significant set bit and an all-zero flag.
module leading_one_detector
  import posit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o
);

  always_comb begin
    idx_o  = '0;
    zero_o = 1'b1;
    for (int i = 0; i < WIDTH; i++)
      if (vec_i[i]) begin
        idx_o  = IDX_W'(i);
        zero_o = 1'b0;
      end
  end

endmodule

// File: rtl/posit_acc_normalizer.sv
// Exact fixed-point accumulation of decoded posit products, normalized for the posit encoder.
// POSIT_ACC_PIPE_EN: registers the leading-one result before the normalizing shifter (NORM1/NORM2).
module posit_acc_normalizer
  import posit_pkg::*;
#(
  parameter int n          = 16,
  parameter int es         = 1,
  parameter int nd         = clog2(n - 1),
  parameter int EXP_WIDTH  = nd + es,
  parameter int MANT_WIDTH = n - es - 3,
  parameter int CARRY_BITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_last_i,
  input  logic                  in_sign_i,
  input  logic [EXP_WIDTH:0]    in_scale_i,
  input  logic [MANT_WIDTH:0]   in_mant_i,
  input  logic                  in_nar_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  sign_o,
  output logic [EXP_WIDTH:0]    rg_exp_o,
  output logic [MANT_WIDTH:0]   mant_norm_o,
  output logic                  nar_o
);

  localparam int SCALE_MAX = scale_max(n, es);
  localparam int ACC_WIDTH = acc_width(n, es, MANT_WIDTH, CARRY_BITS);
  localparam int SH_W      = clog2(2 * SCALE_MAX + 1);
  localparam int IDX_W     = clog2(ACC_WIDTH);

  acc_state_e state_q, state_d;

  logic [ACC_WIDTH-1:0] acc_q;
  logic                 nar_q;
  logic                 accept, out_done, out_load;

  assign accept   = in_valid_i && in_ready_o;
  assign out_done = out_valid_o && out_ready_i;

  // ---------------- term alignment ----------------
  int                   sc_c;
  logic [SH_W-1:0]      shamt;
  logic [ACC_WIDTH-1:0] term_mag, term;

  always_comb begin
    sc_c = int'($signed(in_scale_i));
    if (sc_c > SCALE_MAX)       sc_c = SCALE_MAX;
    else if (sc_c < -SCALE_MAX) sc_c = -SCALE_MAX;
    shamt    = SH_W'(sc_c + SCALE_MAX);
    term_mag = '0;
    // Hidden bit clear marks a zero term regardless of the fraction bits.
    if (in_mant_i[MANT_WIDTH])
      term_mag = ACC_WIDTH'(in_mant_i) << shamt;
    term = in_sign_i ? -term_mag : term_mag;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      nar_q <= 1'b0;
    end else if (accept) begin
      acc_q <= acc_q + term;
      if (in_nar_i) nar_q <= 1'b1;
    end else if (out_done) begin
      acc_q <= '0;
      nar_q <= 1'b0;
    end
  end

  // ---------------- FSM ----------------
`ifdef POSIT_ACC_PIPE_EN
  logic lod_load;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_ACC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_load    = 1'b0;
`ifdef POSIT_ACC_PIPE_EN
    lod_load    = 1'b0;
`endif
    case (state_q)
      ST_ACC: begin
        in_ready_o = 1'b1;
        if (in_valid_i && in_last_i) state_d = ST_NORM;
      end
      ST_NORM: begin
`ifdef POSIT_ACC_PIPE_EN
        lod_load = 1'b1;
        state_d  = ST_NORM2;
`else
        out_load = 1'b1;
        state_d  = ST_OUT;
`endif
      end
      ST_NORM2: begin
        out_load = 1'b1;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  // ---------------- normalization ----------------
  logic [ACC_WIDTH-1:0] mag;
  logic [IDX_W-1:0]     lod_idx;
  logic                 lod_zero;

  assign mag = acc_q[ACC_WIDTH-1] ? -acc_q : acc_q;

  leading_one_detector #(
    .WIDTH (ACC_WIDTH),
    .IDX_W (IDX_W)
  ) u_lod (
    .vec_i  (mag),
    .idx_o  (lod_idx),
    .zero_o (lod_zero)
  );

  logic [ACC_WIDTH-1:0] n_mag;
  logic [IDX_W-1:0]     n_idx;
  logic                 n_zero, n_sign;

`ifdef POSIT_ACC_PIPE_EN
  logic [ACC_WIDTH-1:0] mag_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 zero_q, sign_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mag_q  <= '0;
      idx_q  <= '0;
      zero_q <= 1'b1;
      sign_q <= 1'b0;
    end else if (lod_load) begin
      mag_q  <= mag;
      idx_q  <= lod_idx;
      zero_q <= lod_zero;
      sign_q <= acc_q[ACC_WIDTH-1];
    end
  end

  assign n_mag  = mag_q;
  assign n_idx  = idx_q;
  assign n_zero = zero_q;
  assign n_sign = sign_q;
`else
  assign n_mag  = mag;
  assign n_idx  = lod_idx;
  assign n_zero = lod_zero;
  assign n_sign = acc_q[ACC_WIDTH-1];
`endif

  int                   e_c;
  logic [ACC_WIDTH-1:0] shifted;
  logic                 res_sign;
  logic [EXP_WIDTH:0]   res_exp;
  logic [MANT_WIDTH:0]  res_mant;

  always_comb begin
    e_c      = int'(n_idx) - SCALE_MAX - MANT_WIDTH;
    // Leading one moved to the MSB; zeros shift in below bit 0.
    shifted  = n_mag << (IDX_W'(ACC_WIDTH - 1) - n_idx);
    res_sign = n_sign;
    res_exp  = (EXP_WIDTH+1)'(e_c);
    res_mant = (MANT_WIDTH+1)'(shifted >> (ACC_WIDTH - MANT_WIDTH - 1));
    if (n_zero) begin
      res_sign = 1'b0;
      res_exp  = '0;
      res_mant = '0;
    end else if (e_c > SCALE_MAX) begin
      res_exp  = (EXP_WIDTH+1)'(SCALE_MAX);
      res_mant = '1;
    end else if (e_c < -SCALE_MAX) begin
      // Only reachable through cancellation below minpos; encoder rounds it anyway.
      res_exp  = (EXP_WIDTH+1)'(-SCALE_MAX);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sign_o      <= 1'b0;
      rg_exp_o    <= '0;
      mant_norm_o <= '0;
      nar_o       <= 1'b0;
    end else if (out_load) begin
      sign_o      <= res_sign;
      rg_exp_o    <= res_exp;
      mant_norm_o <= res_mant;
      nar_o       <= nar_q;
    end
  end

endmodule

// File: tb/tb_posit_acc_normalizer.sv
// Directed, table-driven bench for posit_acc_normalizer (n=16, es=1).
module tb_posit_acc_normalizer;

`ifdef POSIT_ACC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, in_sign = 1'b0, in_nar = 1'b0;
  logic [5:0]  in_scale = '0;
  logic [12:0] in_mant = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, sign, nar;
  logic [5:0]  rg_exp;
  logic [12:0] mant_norm;

  int n_chk = 0;
  int n_err = 0;

  posit_acc_normalizer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_last_i   (in_last),
    .in_sign_i   (in_sign),
    .in_scale_i  (in_scale),
    .in_mant_i   (in_mant),
    .in_nar_i    (in_nar),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sign_o      (sign),
    .rg_exp_o    (rg_exp),
    .mant_norm_o (mant_norm),
    .nar_o       (nar)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    int               nt;
    logic [3:0]       sg;
    logic [3:0][5:0]  sc;
    logic [3:0][12:0] mt;
    logic             esg;
    logic [5:0]       eexp;
    logic [12:0]      emt;
  } vec_t;

  function automatic vec_t v(string nm, int nt, logic [3:0] sg,
                             int s0, int s1, int s2, int s3,
                             logic [12:0] m0, logic [12:0] m1, logic [12:0] m2, logic [12:0] m3,
                             logic esg, int eexp, logic [12:0] emt);
    vec_t r;
    r.name = nm; r.nt = nt; r.sg = sg;
    r.sc[0] = 6'(s0); r.sc[1] = 6'(s1); r.sc[2] = 6'(s2); r.sc[3] = 6'(s3);
    r.mt[0] = m0; r.mt[1] = m1; r.mt[2] = m2; r.mt[3] = m3;
    r.esg = esg; r.eexp = 6'(eexp); r.emt = emt;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drives one term and lets it be taken on the next edge; returns #1 after that edge.
  task automatic send_term(string nm, logic sg, logic [5:0] sc, logic [12:0] mt, logic nr, logic last);
    in_valid = 1'b1; in_sign = sg; in_scale = sc; in_mant = mt; in_nar = nr; in_last = last;
    chk({nm, "_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_nar = 1'b0;
  endtask

  task automatic wait_out(string nm);
    int cnt;
    cnt = 0;
    chk({nm, "_ready_norm"}, 32'(in_ready), 32'd0);
    while (!out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({nm, "_latency"}, 32'(cnt), 32'(LAT));
  endtask

  task automatic handshake(string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_vld_clr"}, 32'(out_valid), 32'd0);
    chk({nm, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_vec(vec_t t);
    for (int i = 0; i < t.nt; i++)
      send_term(t.name, t.sg[i], t.sc[i], t.mt[i], 1'b0, (i == t.nt - 1));
    wait_out(t.name);
    chk({t.name, "_sign"}, 32'(sign), 32'(t.esg));
    chk({t.name, "_exp"},  32'(rg_exp), 32'(t.eexp));
    chk({t.name, "_mant"}, 32'(mant_norm), 32'(t.emt));
    chk({t.name, "_nar"},  32'(nar), 32'd0);
    handshake(t.name);
  endtask

  vec_t vt[$];

  initial begin
    vec_t snap;
    vt.push_back(v("one",      1, 4'b0000,   0,   0, 0, 0, 13'h1000, 13'h0000, 0, 0,        1'b0,   0, 13'h1000));
    vt.push_back(v("two",      2, 4'b0000,   0,   0, 0, 0, 13'h1000, 13'h1000, 0, 0,        1'b0,   1, 13'h1000));
    vt.push_back(v("half",     2, 4'b0010,   0,   0, 0, 0, 13'h1800, 13'h1000, 0, 0,        1'b0,  -1, 13'h1000));
    vt.push_back(v("cancel",   2, 4'b0010,   0,   0, 0, 0, 13'h1000, 13'h1000, 0, 0,        1'b0,   0, 13'h0000));
    vt.push_back(v("sat",      2, 4'b0000,  28,  28, 0, 0, 13'h1FFF, 13'h1FFF, 0, 0,        1'b0,  28, 13'h1FFF));
    vt.push_back(v("clamp_lo", 1, 4'b0000, -32,   0, 0, 0, 13'h1000, 13'h0000, 0, 0,        1'b0, -28, 13'h1000));
    vt.push_back(v("clamp_hi", 1, 4'b0000,  31,   0, 0, 0, 13'h1000, 13'h0000, 0, 0,        1'b0,  28, 13'h1000));
    vt.push_back(v("neg",      1, 4'b0001,   3,   0, 0, 0, 13'h1800, 13'h0000, 0, 0,        1'b1,   3, 13'h1800));
    vt.push_back(v("carry",    2, 4'b0000,   0, -12, 0, 0, 13'h1FFF, 13'h1001, 0, 0,        1'b0,   1, 13'h1000));
    vt.push_back(v("zterm",    2, 4'b0000,   5,   2, 0, 0, 13'h0FFF, 13'h1000, 0, 0,        1'b0,   2, 13'h1000));
    vt.push_back(v("mixed",    2, 4'b0010,   2,   0, 0, 0, 13'h1000, 13'h1000, 0, 0,        1'b0,   1, 13'h1800));
    vt.push_back(v("four",     4, 4'b0000,   0,   0, 0, 0, 13'h1000, 13'h1000, 13'h1000, 13'h1000, 1'b0, 2, 13'h1000));
    vt.push_back(v("negsum",   2, 4'b0010,   0,   1, 0, 0, 13'h1000, 13'h1000, 0, 0,        1'b1,   0, 13'h1000));

    // Reset state, no clock edge needed with an asynchronous reset.
    #2;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sign",  32'(sign), 32'd0);
    chk("rst_exp",   32'(rg_exp), 32'd0);
    chk("rst_mant",  32'(mant_norm), 32'd0);
    chk("rst_nar",   32'(nar), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);

    // NaR mid-stream, then back-pressure for three cycles.
    send_term("nar_a", 1'b0, 6'd0, 13'h1000, 1'b0, 1'b0);
    send_term("nar_b", 1'b0, 6'd0, 13'h0000, 1'b1, 1'b0);
    send_term("nar_c", 1'b0, 6'd0, 13'h1000, 1'b0, 1'b1);
    wait_out("nar");
    chk("nar_flag", 32'(nar), 32'd1);
    snap.esg = sign; snap.eexp = rg_exp; snap.emt = mant_norm;
    in_valid = 1'b1; in_last = 1'b1; in_mant = 13'h1000; in_scale = 6'd5;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_nar",   32'(nar), 32'd1);
      chk("hold_sign",  32'(sign), 32'(snap.esg));
      chk("hold_exp",   32'(rg_exp), 32'(snap.eexp));
      chk("hold_mant",  32'(mant_norm), 32'(snap.emt));
    end
    in_valid = 1'b0; in_last = 1'b0;
    handshake("nar");
    run_vec(v("after_nar", 1, 4'b0000, 0, 0, 0, 0, 13'h1000, 0, 0, 0, 1'b0, 0, 13'h1000));

    // Reset while normalizing discards the sum and clears outputs immediately.
    send_term("rnorm", 1'b0, 6'd3, 13'h1000, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("rnorm_valid", 32'(out_valid), 32'd0);
    chk("rnorm_ready", 32'(in_ready), 32'd1);
    chk("rnorm_sign",  32'(sign), 32'd0);
    chk("rnorm_exp",   32'(rg_exp), 32'd0);
    chk("rnorm_mant",  32'(mant_norm), 32'd0);
    chk("rnorm_nar",   32'(nar), 32'd0);
    #1 rst = 1'b0;
    run_vec(v("post_rst", 1, 4'b0000, 1, 0, 0, 0, 13'h1800, 0, 0, 0, 1'b0, 1, 13'h1800));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_chk);
    $fatal(1);
  end

endmodule
